// File: rtl/sccb_pkg.sv
// SCCB init sequencer shared types and camera register constants.
package sccb_pkg;

  typedef enum logic [2:0] {
    S_BOOT,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_GAP,
    S_SETTLE,
    S_DONE,
    S_FAIL
  } sccb_state_t;

  localparam logic [7:0]  ENT_DELAY = 8'hFF;
  localparam logic [15:0] ENT_END   = 16'hFFFF;

  localparam logic [7:0] REG_CLKRC    = 8'h11;
  localparam logic [7:0] REG_COM7     = 8'h12;
  localparam logic [7:0] REG_HSTART   = 8'h17;
  localparam logic [7:0] REG_HSTOP    = 8'h18;
  localparam logic [7:0] REG_TSLB     = 8'h3A;
  localparam logic [7:0] REG_COM15    = 8'h40;
  localparam logic [7:0] REG_RGB444   = 8'h8C;

  localparam logic [7:0] COM7_RESET   = 8'h80;
  localparam logic [7:0] COM7_RGB     = 8'h04;
  localparam logic [7:0] COM15_RGB565 = 8'hD0;

endpackage

// File: rtl/sccb_init_rom.sv
// Camera init table: index -> {reg, val}; delay and end entries use reg FF.
module sccb_init_rom
  import sccb_pkg::*;
#(
  parameter int IW = 6
)(
  input  logic [IW-1:0] idx,
  output logic [15:0]   ent
);

  logic [7:0] a;
  assign a = 8'(idx);

  always_comb begin
    unique case (a)
      8'd0:    ent = {REG_COM7, COM7_RESET};
      8'd1:    ent = {ENT_DELAY, 8'h20};
      8'd2:    ent = {REG_CLKRC, 8'h01};
      8'd3:    ent = {REG_COM7, COM7_RGB};
      8'd4:    ent = {REG_COM15, COM15_RGB565};
      8'd5:    ent = {REG_RGB444, 8'h00};
      8'd6:    ent = {REG_TSLB, 8'h04};
      8'd7:    ent = {ENT_DELAY, 8'h00};
      8'd8:    ent = {REG_HSTART, 8'h13};
      8'd9:    ent = {REG_HSTOP, 8'h01};
      default: ent = ENT_END;
    endcase
  end

endmodule

// File: rtl/sccb_init_sequencer.sv
// Walks the init ROM and issues one SCCB write per entry via i2c_control,
// with boot hold-off, inter-write gaps, table delays and NACK retries.
module sccb_init_sequencer
  import sccb_pkg::*;
#(
  parameter logic [7:0]  DEV_ADDR    = 8'h42,
  parameter int          NUM_ENTRIES = 64,
  parameter logic [23:0] BOOT_WAIT   = 24'd1_000_000,
  parameter logic [15:0] GAP_CYCLES  = 16'd2000,
  parameter logic [15:0] DELAY_UNIT  = 16'd50_000,
  parameter int          MAX_RETRY   = 3,
  localparam int         IW          = $clog2(NUM_ENTRIES)
)(
  input  logic          clk,
  input  logic          res,
  input  logic          start,
  output logic          i2c_req,
  output logic [7:0]    i2c_dev,
  output logic [7:0]    i2c_reg,
  output logic [7:0]    i2c_data,
  input  logic          i2c_done,
  input  logic          i2c_nack,
  output logic          cfg_busy,
  output logic          cfg_done,
  output logic          cfg_error,
  output logic [IW-1:0] cfg_index
);

  localparam int          RW   = $clog2(MAX_RETRY + 2);
  localparam logic [RW-1:0] MR = RW'(MAX_RETRY);
  localparam logic [IW-1:0] LAST = IW'(NUM_ENTRIES - 1);

  sccb_state_t   state;
  logic [23:0]   cnt;
  logic [7:0]    dval;
  logic [RW-1:0] retry;
  logic          last;
  logic [15:0]   rom_q;
  logic [23:0]   delay_cyc;
  logic [23:0]   gap_end;

  sccb_init_rom #(.IW(IW)) u_rom (
    .idx (cfg_index),
    .ent (rom_q)
  );

  assign i2c_dev   = DEV_ADDR;
  assign delay_cyc = 24'(dval) * 24'(DELAY_UNIT);
  assign gap_end   = {8'd0, GAP_CYCLES};

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state     <= S_BOOT;
      cnt       <= '0;
      dval      <= '0;
      retry     <= '0;
      last      <= 1'b0;
      i2c_req   <= 1'b0;
      i2c_reg   <= '0;
      i2c_data  <= '0;
      cfg_busy  <= 1'b1;
      cfg_done  <= 1'b0;
      cfg_error <= 1'b0;
      cfg_index <= '0;
    end else begin
      unique case (state)
        S_BOOT: begin
          if (cnt == BOOT_WAIT) begin
            cnt   <= '0;
            state <= S_FETCH;
          end else begin
            cnt <= cnt + 24'd1;
          end
        end
        S_FETCH: begin
          dval <= rom_q[7:0];
          cnt  <= '0;
          if (rom_q == ENT_END) begin
            state    <= S_DONE;
            cfg_busy <= 1'b0;
            cfg_done <= 1'b1;
          end else if (rom_q[15:8] == ENT_DELAY) begin
            state <= S_SETTLE;
          end else begin
            state    <= S_ISSUE;
            i2c_req  <= 1'b1;
            i2c_reg  <= rom_q[15:8];
            i2c_data <= rom_q[7:0];
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (i2c_done) begin
            i2c_req <= 1'b0;
            cnt     <= '0;
            if (!i2c_nack) begin
              retry <= '0;
              last  <= (cfg_index == LAST);
              state <= S_GAP;
              if (cfg_index != LAST)
                cfg_index <= cfg_index + IW'(1);
            end else if (retry != MR) begin
              retry <= retry + RW'(1);
              last  <= 1'b0;
              state <= S_GAP;
            end else begin
              state     <= S_FAIL;
              cfg_busy  <= 1'b0;
              cfg_error <= 1'b1;
            end
          end
        end
        S_GAP: begin
          if (cnt + 24'd1 >= gap_end) begin
            cnt <= '0;
            if (last) begin
              state    <= S_DONE;
              cfg_busy <= 1'b0;
              cfg_done <= 1'b1;
            end else begin
              state <= S_FETCH;
            end
          end else begin
            cnt <= cnt + 24'd1;
          end
        end
        // A zero delay still spends this one cycle here.
        S_SETTLE: begin
          if (cnt >= delay_cyc) begin
            cnt <= '0;
            if (cfg_index == LAST) begin
              state    <= S_DONE;
              cfg_busy <= 1'b0;
              cfg_done <= 1'b1;
            end else begin
              cfg_index <= cfg_index + IW'(1);
              state     <= S_FETCH;
            end
          end else begin
            cnt <= cnt + 24'd1;
          end
        end
        S_DONE, S_FAIL: begin
          if (start) begin
            state     <= S_FETCH;
            cfg_index <= '0;
            retry     <= '0;
            last      <= 1'b0;
            cfg_busy  <= 1'b1;
            cfg_done  <= 1'b0;
            cfg_error <= 1'b0;
          end
        end
        default: state <= S_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Randomized bench for sccb_init_sequencer against a table-walk model.
module tb_sccb_init_sequencer;

  localparam logic [7:0] DEV = 8'h42;
  localparam int BW  = 10;
  localparam int GAP = 4;
  localparam int DU  = 3;
  localparam int MR  = 3;
  localparam int NE  = 64;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       res4 = 1'b1;
  logic       start = 1'b0;
  logic       i2c_req, i2c_done, i2c_nack;
  logic [7:0] i2c_dev, i2c_reg, i2c_data;
  logic       cfg_busy, cfg_done, cfg_error;
  logic [5:0] cfg_index;

  logic       req4, done4, nack4;
  logic [7:0] dev4, reg4, data4;
  logic       busy4, cdone4, err4;
  logic [1:0] idx4;

  always #5 clk = ~clk;

  sccb_init_sequencer #(
    .DEV_ADDR(DEV), .NUM_ENTRIES(NE), .BOOT_WAIT(24'(BW)),
    .GAP_CYCLES(16'(GAP)), .DELAY_UNIT(16'(DU)), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .res(res), .start(start),
    .i2c_req(i2c_req), .i2c_dev(i2c_dev), .i2c_reg(i2c_reg),
    .i2c_data(i2c_data), .i2c_done(i2c_done), .i2c_nack(i2c_nack),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_error(cfg_error),
    .cfg_index(cfg_index)
  );

  sccb_init_sequencer #(
    .DEV_ADDR(DEV), .NUM_ENTRIES(4), .BOOT_WAIT(24'(BW)),
    .GAP_CYCLES(16'(GAP)), .DELAY_UNIT(16'(DU)), .MAX_RETRY(MR)
  ) dut4 (
    .clk(clk), .res(res4), .start(1'b0),
    .i2c_req(req4), .i2c_dev(dev4), .i2c_reg(reg4),
    .i2c_data(data4), .i2c_done(done4), .i2c_nack(nack4),
    .cfg_busy(busy4), .cfg_done(cdone4), .cfg_error(err4),
    .cfg_index(idx4)
  );

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // golden copy of the camera table
  logic [15:0] tbl [64];
  int nk [64];
  int scen = 0;
  int lat_lo = 5;
  int lat_hi = 5;

  // i2c_control model for the main instance
  logic [31:0] req_q [$];
  int req_cyc [$];
  int done_cyc [$];
  int nleft [64];
  int seen_scen = -1;
  int lat = 0;
  bit busy_r = 0;
  int drops = 0;
  logic [15:0] cur;

  always @(negedge clk) begin
    i2c_done = 1'b0;
    i2c_nack = 1'b0;
    if (seen_scen != scen) begin
      seen_scen = scen;
      foreach (nleft[i]) nleft[i] = nk[i];
    end
    if (res) begin
      busy_r = 0;
    end else if (busy_r) begin
      if (!i2c_req || {i2c_reg, i2c_data} != cur) drops++;
      lat--;
      if (lat <= 0) begin
        i2c_done = 1'b1;
        busy_r = 0;
        done_cyc.push_back(cyc);
        if (nleft[cfg_index] > 0) begin
          i2c_nack = 1'b1;
          nleft[cfg_index]--;
        end
      end
    end else if (i2c_req) begin
      cur = {i2c_reg, i2c_data};
      req_q.push_back({8'(cfg_index), i2c_dev, i2c_reg, i2c_data});
      req_cyc.push_back(cyc);
      lat = int'($urandom_range(lat_hi, lat_lo));
      busy_r = 1;
    end
  end

  logic [31:0] req4_q [$];
  int lat4 = 0;
  bit busy4_r = 0;

  always @(negedge clk) begin
    done4 = 1'b0;
    nack4 = 1'b0;
    if (res4) begin
      busy4_r = 0;
    end else if (busy4_r) begin
      lat4--;
      if (lat4 <= 0) begin
        done4 = 1'b1;
        busy4_r = 0;
      end
    end else if (req4) begin
      req4_q.push_back({8'(idx4), dev4, reg4, data4});
      lat4 = 2;
      busy4_r = 1;
    end
  end

  // expected request stream derived from table rules
  logic [31:0] exp_q [$];
  int exp_fin;
  bit exp_fail;

  task automatic model(input int ne);
    int reps;
    exp_q.delete();
    exp_fail = 0;
    exp_fin = 0;
    for (int i = 0; i < ne; i++) begin
      exp_fin = i;
      if (tbl[i] == 16'hFFFF) break;
      if (tbl[i][15:8] == 8'hFF) continue;
      reps = (nk[i] > MR) ? MR + 1 : nk[i] + 1;
      for (int r = 0; r < reps; r++)
        exp_q.push_back({8'(i), DEV, tbl[i]});
      if (nk[i] > MR) begin
        exp_fail = 1;
        break;
      end
    end
  endtask

  task automatic cmp_run(input string nm, input logic [31:0] q [$],
                         input int base);
    chk({nm, "_nreq"}, 32'(q.size() - base), 32'(exp_q.size()));
    foreach (exp_q[j])
      chk($sformatf("%s_req%0d", nm, j), q[base + j], exp_q[j]);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (cfg_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle", 32'(cfg_busy), 32'd0);
  endtask

  task automatic wait_req(input int budget);
    int n = 0;
    while (!i2c_req && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", 32'(i2c_req), 32'd1);
  endtask

  int st_cyc;
  task automatic pulse_start();
    start = 1'b1;
    st_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_status(input string nm, input bit d, input bit e,
                            input int idx);
    chk({nm, "_done"}, 32'(cfg_done), 32'(d));
    chk({nm, "_err"}, 32'(cfg_error), 32'(e));
    chk({nm, "_busy"}, 32'(cfg_busy), 32'd0);
    chk({nm, "_req"}, 32'(i2c_req), 32'd0);
    chk({nm, "_idx"}, 32'(cfg_index), 32'(idx));
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_req"}, 32'(i2c_req), 32'd0);
    chk({nm, "_dev"}, 32'(i2c_dev), 32'(DEV));
    chk({nm, "_reg"}, 32'(i2c_reg), 32'd0);
    chk({nm, "_data"}, 32'(i2c_data), 32'd0);
    chk({nm, "_busy"}, 32'(cfg_busy), 32'd1);
    chk({nm, "_done"}, 32'(cfg_done), 32'd0);
    chk({nm, "_err"}, 32'(cfg_error), 32'd0);
    chk({nm, "_idx"}, 32'(cfg_index), 32'd0);
  endtask

  int base, rel, st, n4, v;

  initial begin
    for (int i = 0; i < 64; i++) begin
      tbl[i] = 16'hFFFF;
      nk[i] = 0;
    end
    tbl[0] = 16'h1280; tbl[1] = 16'hFF20; tbl[2] = 16'h1101;
    tbl[3] = 16'h1204; tbl[4] = 16'h40D0; tbl[5] = 16'h8C00;
    tbl[6] = 16'h3A04; tbl[7] = 16'hFF00; tbl[8] = 16'h1713;
    tbl[9] = 16'h1801;

    repeat (3) @(negedge clk);
    chk_reset("rst");

    // power-up walk, every write acked after 5 cycles
    base = req_q.size();
    rel = cyc;
    res = 1'b0;
    res4 = 1'b0;
    wait_idle(3000);
    model(NE);
    cmp_run("boot", req_q, base);
    chk("boot_lat", 32'(req_cyc[base] - rel), 32'(BW + 2));
    chk("gap_lat", 32'(req_cyc[base + 2] - done_cyc[base + 1]), 32'(GAP + 2));
    chk("delay_min",
        32'((req_cyc[base + 1] - done_cyc[base]) >= 32 * DU), 32'd1);
    chk_status("boot", 1, 0, exp_fin);

    // short table with no end marker
    n4 = 0;
    while (busy4 && n4 < 3000) begin
      @(negedge clk);
      n4++;
    end
    model(4);
    cmp_run("nomark", req4_q, 0);
    chk("nomark_done", 32'(cdone4), 32'd1);
    chk("nomark_err", 32'(err4), 32'd0);
    chk("nomark_busy", 32'(busy4), 32'd0);

    // rerun from DONE, entry 2 NACKed twice, stray start during WAIT
    scen++;
    nk[2] = 2;
    base = req_q.size();
    pulse_start();
    st = st_cyc;
    wait_req(100);
    @(negedge clk);
    pulse_start();
    wait_idle(3000);
    model(NE);
    cmp_run("retry", req_q, base);
    chk("restart_lat", 32'(req_cyc[base] - st), 32'd2);
    chk_status("retry", 1, 0, exp_fin);

    // entry 3 never acked: retries exhausted
    scen++;
    nk[2] = 0;
    nk[3] = 99;
    base = req_q.size();
    pulse_start();
    wait_idle(3000);
    model(NE);
    cmp_run("fail", req_q, base);
    chk_status("fail", 0, 1, 3);

    // random NACK patterns and ack latencies
    for (int k = 0; k < 4; k++) begin
      scen++;
      for (int i = 0; i < 64; i++) begin
        v = int'($urandom_range(19, 0));
        nk[i] = (v < 12) ? 0 : (v < 18) ? (v % 3) + 1 : 9;
      end
      lat_lo = 1;
      lat_hi = 6;
      base = req_q.size();
      pulse_start();
      wait_idle(4000);
      model(NE);
      cmp_run($sformatf("rnd%0d", k), req_q, base);
      chk_status($sformatf("rnd%0d", k), !exp_fail, exp_fail, exp_fin);
    end

    // reset while a request is outstanding
    scen++;
    for (int i = 0; i < 64; i++) nk[i] = 0;
    lat_lo = 5;
    lat_hi = 5;
    pulse_start();
    wait_req(100);
    @(negedge clk);
    res = 1'b1;
    #1;
    chk_reset("midrst");
    repeat (2) @(negedge clk);
    base = req_q.size();
    rel = cyc;
    res = 1'b0;
    wait_idle(3000);
    model(NE);
    cmp_run("reboot", req_q, base);
    chk("reboot_lat", 32'(req_cyc[base] - rel), 32'(BW + 2));
    chk_status("reboot", 1, 0, exp_fin);

    chk("req_hold", 32'(drops), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
